// File: rtl/output_serializer.sv
// Stereo parallel-to-serial output stage: buffers one result per channel and
// shifts both words out MSB-first in lockstep once both channels have data.
module output_serializer #(
  parameter int unsigned WIDTH = 40
) (
  input  logic             Sclk,
  input  logic             uni_reset_n,
  input  logic             ALU_finish_L,
  input  logic             ALU_finish_R,
  input  logic [WIDTH-1:0] output_data_L,
  input  logic [WIDTH-1:0] output_data_R,
  output logic             OutReady,
  output logic             OutputL,
  output logic             OutputR,
  output logic             tx_busy,
  output logic             overrun
);

  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] hold_L;
  logic [WIDTH-1:0] hold_R;
  logic [WIDTH-1:0] shift_L;
  logic [WIDTH-1:0] shift_R;
  logic             vL;
  logic             vR;
  logic             load;

  always_comb begin
    load     = 1'b0;
    state_nx = state;
    case (state)
      IDLE: begin
        if (vL && vR) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        // The last bit's edge doubles as the reload edge, so back-to-back words have no gap.
        if (bit_cnt == LAST) begin
          if (vL && vR) load = 1'b1;
          else          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Sclk or negedge uni_reset_n) begin
    if (!uni_reset_n) state <= IDLE;
    else              state <= state_nx;
  end

  always_ff @(posedge Sclk or negedge uni_reset_n) begin
    if (!uni_reset_n) begin
      shift_L <= '0;
      shift_R <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shift_L <= hold_L;
      shift_R <= hold_R;
      bit_cnt <= '0;
    end else if (state == SHIFT) begin
      shift_L <= shift_L << 1;
      shift_R <= shift_R << 1;
      bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
    end
  end

  // A capture on the consume edge takes priority over clearing the valid flag.
  always_ff @(posedge Sclk or negedge uni_reset_n) begin
    if (!uni_reset_n) begin
      hold_L <= '0;
      vL     <= 1'b0;
    end else if (ALU_finish_L && (!vL || load)) begin
      hold_L <= output_data_L;
      vL     <= 1'b1;
    end else if (load) begin
      vL     <= 1'b0;
    end
  end

  always_ff @(posedge Sclk or negedge uni_reset_n) begin
    if (!uni_reset_n) begin
      hold_R <= '0;
      vR     <= 1'b0;
    end else if (ALU_finish_R && (!vR || load)) begin
      hold_R <= output_data_R;
      vR     <= 1'b1;
    end else if (load) begin
      vR     <= 1'b0;
    end
  end

  always_ff @(posedge Sclk or negedge uni_reset_n) begin
    if (!uni_reset_n) begin
      overrun <= 1'b0;
    end else if ((ALU_finish_L && vL && !load) || (ALU_finish_R && vR && !load)) begin
      overrun <= 1'b1;
    end
  end

  assign OutReady = (state == SHIFT);
  assign tx_busy  = (state == SHIFT);
  assign OutputL  = (state == SHIFT) && shift_L[WIDTH-1];
  assign OutputR  = (state == SHIFT) && shift_R[WIDTH-1];

endmodule

// File: tb/tb_output_serializer.sv
// Directed + randomized bench for output_serializer against a bit-stream
// reference model built from queues of expected serial bit pairs.
module tb_output_serializer;

  localparam int unsigned W = 40;

  logic         Sclk;
  logic         uni_reset_n;
  logic         ALU_finish_L;
  logic         ALU_finish_R;
  logic [W-1:0] output_data_L;
  logic [W-1:0] output_data_R;
  logic         OutReady;
  logic         OutputL;
  logic         OutputR;
  logic         tx_busy;
  logic         overrun;

  output_serializer #(.WIDTH(W)) dut (
    .Sclk          (Sclk),
    .uni_reset_n   (uni_reset_n),
    .ALU_finish_L  (ALU_finish_L),
    .ALU_finish_R  (ALU_finish_R),
    .output_data_L (output_data_L),
    .output_data_R (output_data_R),
    .OutReady      (OutReady),
    .OutputL       (OutputL),
    .OutputR       (OutputR),
    .tx_busy       (tx_busy),
    .overrun       (overrun)
  );

  initial Sclk = 1'b0;
  always #5 Sclk = ~Sclk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending serial bit pairs {L,R}; front is the bit on the wire now.
  logic [1:0]   exp_q[$];
  logic [W-1:0] m_hold_l, m_hold_r;
  logic         m_vl, m_vr, m_ovr;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all();
    logic rdy, el, er;
    rdy = (exp_q.size() > 0);
    el  = rdy ? exp_q[0][1] : 1'b0;
    er  = rdy ? exp_q[0][0] : 1'b0;
    chk("OutReady", OutReady, rdy);
    chk("tx_busy",  tx_busy,  rdy);
    chk("OutputL",  OutputL,  el);
    chk("OutputR",  OutputR,  er);
    chk("overrun",  overrun,  m_ovr);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_hold_l = '0;
    m_hold_r = '0;
    m_vl     = 1'b0;
    m_vr     = 1'b0;
    m_ovr    = 1'b0;
  endtask

  task automatic model_edge(input logic fl, input logic fr,
                            input logic [W-1:0] dl, input logic [W-1:0] dr);
    logic ld;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    ld = m_vl && m_vr && (exp_q.size() == 0);
    if (ld)
      for (int i = W - 1; i >= 0; i--) exp_q.push_back({m_hold_l[i], m_hold_r[i]});
    if (fl) begin
      if (!m_vl || ld) begin m_hold_l = dl; m_vl = 1'b1; end
      else m_ovr = 1'b1;
    end else if (ld) m_vl = 1'b0;
    if (fr) begin
      if (!m_vr || ld) begin m_hold_r = dr; m_vr = 1'b1; end
      else m_ovr = 1'b1;
    end else if (ld) m_vr = 1'b0;
  endtask

  // Called at posedge+1: drive, take one edge, update model, check.
  task automatic tick(input logic fl, input logic fr,
                      input logic [W-1:0] dl, input logic [W-1:0] dr);
    ALU_finish_L  = fl;
    ALU_finish_R  = fr;
    output_data_L = dl;
    output_data_R = dr;
    @(posedge Sclk);
    model_edge(fl, fr, dl, dr);
    #1;
    chk_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, rnd40(), rnd40());
  endtask

  function automatic logic [W-1:0] rnd40();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[W-1:0];
  endfunction

  // Idle until the model's remaining-bit count hits the target (bounded).
  task automatic idle_until_left(input int left);
    int guard;
    guard = 0;
    while (exp_q.size() != left && guard < 200) begin
      idle(1);
      guard++;
    end
    chk("wait_bound", guard < 200, 1'b1);
  endtask

  logic [W-1:0] a, b, c, r1, r2;

  initial begin
    ALU_finish_L  = 1'b0;
    ALU_finish_R  = 1'b0;
    output_data_L = '0;
    output_data_R = '0;
    uni_reset_n   = 1'b0;
    model_reset();
    #12;
    chk_all();
    @(posedge Sclk);
    #3 uni_reset_n = 1'b1;
    @(posedge Sclk);
    #1;
    chk_all();

    // Basic word: L = 1 0...0 1, R is its complement
    tick(1'b1, 1'b1, 40'h80_0000_0001, 40'h7F_FFFF_FFFE);
    idle(45);

    // Skewed finishes: L at cycle 0, R at cycle 17
    tick(1'b1, 1'b0, rnd40(), '0);
    idle(16);
    tick(1'b0, 1'b1, '0, rnd40());
    idle(45);

    // Back-to-back: second pair arrives at bit 20 of the first word
    tick(1'b1, 1'b1, rnd40(), rnd40());
    idle(1);
    idle_until_left(W - 20);
    tick(1'b1, 1'b1, rnd40(), rnd40());
    idle(90);

    // Capture on the reload edge: held L word with no overrun
    tick(1'b1, 1'b1, rnd40(), rnd40());
    idle(3);
    tick(1'b1, 1'b1, rnd40(), rnd40());
    idle_until_left(1);
    tick(1'b1, 1'b0, 40'hA5_5A5A_A55A, '0);
    idle(W + 5);
    tick(1'b0, 1'b1, '0, rnd40());
    idle(W + 5);

    // Overrun: A sent with R, B captured during shift, C dropped
    a = rnd40(); b = rnd40(); c = rnd40(); r1 = rnd40(); r2 = rnd40();
    tick(1'b1, 1'b1, a, r1);
    idle(5);
    tick(1'b1, 1'b0, b, '0);
    idle(5);
    tick(1'b1, 1'b0, c, '0);
    idle(W + 10);
    tick(1'b0, 1'b1, '0, r2);
    idle(W + 5);

    // Randomized finish traffic
    for (int i = 0; i < 400; i++)
      tick(($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0), rnd40(), rnd40());
    idle(2 * W + 5);

    // Reset mid-word at bit 10
    tick(1'b1, 1'b1, rnd40(), rnd40());
    idle(1);
    idle_until_left(W - 10);
    tick(1'b1, 1'b0, rnd40(), '0);
    #3 uni_reset_n = 1'b0;
    model_reset();
    #1;
    chk_all();
    #2 uni_reset_n = 1'b1;
    idle(W + 10);
    tick(1'b0, 1'b1, '0, rnd40());
    idle(10);
    tick(1'b1, 1'b0, rnd40(), '0);
    idle(W + 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
